// File: rtl/rv_opnd_fetch_if.sv
// rv_opnd_fetch_if: decode-side and execute-side valid/ready channels of the operand-fetch stage
interface rv_opnd_fetch_if #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [4:0]        out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_ctrl, out_ready,
    input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_ctrl
  );
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_ctrl, out_ready,
    output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_ctrl
  );
endinterface

// File: rtl/rv_opnd_fetch.sv
// rv_opnd_fetch: two-stage operand fetch (RF read in flight, output register) with writeback bypass/snoop
module rv_opnd_fetch #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  rv_opnd_fetch_if.slave   bus,
  output logic [4:0]       rf_rd_reg1,
  output logic [4:0]       rf_rd_reg2,
  input  logic [XLEN-1:0]  rf_rd_data1,
  input  logic [XLEN-1:0]  rf_rd_data2,
  input  logic             wb_en,
  input  logic [4:0]       wb_reg,
  input  logic [XLEN-1:0]  wb_data
);
  logic              s1_v, s2_v, s2_adv, accept;
  logic [4:0]        s1_rs1, s1_rs2, s1_rd, s2_rs1, s2_rs2, s2_rd;
  logic [CTRL_W-1:0] s1_ctrl, s2_ctrl;
  logic              hit1, hit2;
  logic [XLEN-1:0]   byp1, byp2, op1, op2, s2_op1, s2_op2;

  function automatic logic wb_hit(input logic [4:0] r);
    return wb_en && wb_reg != 5'd0 && wb_reg == r;
  endfunction

  assign s2_adv        = s1_v & (~s2_v | bus.out_ready);
  assign bus.in_ready  = ~s1_v | s2_adv;
  assign accept        = bus.in_valid & bus.in_ready & ~flush;
  // a stalled S1 keeps re-reading its own sources so RF data never goes stale
  assign rf_rd_reg1    = (s1_v & ~s2_adv) ? s1_rs1 : bus.in_rs1;
  assign rf_rd_reg2    = (s1_v & ~s2_adv) ? s1_rs2 : bus.in_rs2;
  assign op1           = (s1_rs1 == 5'd0) ? '0 : hit1 ? byp1 : rf_rd_data1;
  assign op2           = (s1_rs2 == 5'd0) ? '0 : hit2 ? byp2 : rf_rd_data2;
  assign bus.out_valid    = s2_v;
  assign bus.out_rs1_data = s2_op1;
  assign bus.out_rs2_data = s2_op2;
  assign bus.out_rd       = s2_rd;
  assign bus.out_ctrl     = s2_ctrl;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      hit1    <= 1'b0;
      hit2    <= 1'b0;
      byp1    <= '0;
      byp2    <= '0;
      s1_rs1  <= '0;
      s1_rs2  <= '0;
      s1_rd   <= '0;
      s1_ctrl <= '0;
      s2_rs1  <= '0;
      s2_rs2  <= '0;
      s2_rd   <= '0;
      s2_ctrl <= '0;
      s2_op1  <= '0;
      s2_op2  <= '0;
    end else begin
      hit1 <= wb_hit(rf_rd_reg1);
      hit2 <= wb_hit(rf_rd_reg2);
      byp1 <= wb_data;
      byp2 <= wb_data;
      s1_v <= flush ? 1'b0 : accept ? 1'b1 : s2_adv ? 1'b0 : s1_v;
      s2_v <= flush ? 1'b0 : s2_adv ? 1'b1 : bus.out_ready ? 1'b0 : s2_v;
      if (accept) begin
        s1_rs1  <= bus.in_rs1;
        s1_rs2  <= bus.in_rs2;
        s1_rd   <= bus.in_rd;
        s1_ctrl <= bus.in_ctrl;
      end
      // a writeback on the transfer edge itself is forwarded so S2 never starts stale
      if (s2_adv) begin
        s2_rs1  <= s1_rs1;
        s2_rs2  <= s1_rs2;
        s2_rd   <= s1_rd;
        s2_ctrl <= s1_ctrl;
        s2_op1  <= wb_hit(s1_rs1) ? wb_data : op1;
        s2_op2  <= wb_hit(s1_rs2) ? wb_data : op2;
      end else if (s2_v & ~bus.out_ready) begin
        if (wb_hit(s2_rs1)) s2_op1 <= wb_data;
        if (wb_hit(s2_rs2)) s2_op2 <= wb_data;
      end
    end
endmodule
